mem_arbiter: RTL and testbench

- Shares the single 32-bit memory port (address/write-data/write-strobe/read-start, plus readrdy/saverdy completion) between two requesters: the CPU memory controller and the DMA engine.
- Serialises one transaction at a time and holds address/data stable until the memory side completes.
- Routes read data and a done pulse back to the owning requester.
- CPU has fixed priority; a starvation counter guarantees DMA progress; a timeout recovers from a missing completion.

---
 rtl/mem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the CPU controller and the DMA
// engine. One transaction at a time; CPU has fixed priority, a starvation
// counter guarantees DMA progress, and a WAIT timeout recovers from a
// completion that never arrives.
module mem_arbiter #(
  parameter int unsigned AW      = 15,
  parameter int unsigned DW      = 32,
  parameter int unsigned STARVE  = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_w,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_done,
  input  logic          dma_req,
  input  logic          dma_w,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_done,
  output logic          err,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_w,
  output logic          mem_start,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_readrdy,
  input  logic          mem_saverdy,
  output logic [1:0]    grant,
  output logic          busy
);

  localparam int unsigned SW = $clog2(STARVE + 1);
  localparam int unsigned TW = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state, state_d;
  logic          owner_dma;   // 0 = CPU, 1 = DMA
  logic          w_l;         // latched write flag of the current transaction
  logic          mask;        // first IDLE cycle after DONE: owner_dma is masked
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] to_cnt;

  logic          cpu_ok, dma_ok;
  logic          win_cpu, win_dma, win, w_next;
  logic          complete, timeout_hit;
  logic [1:0]    grant_d;

  // Just-served requester cannot be re-granted in the cycle after DONE; its raw
  // request still counts as contention for the DMA priority rule.
  assign cpu_ok = cpu_req & ~(mask & ~owner_dma);
  assign dma_ok = dma_req & ~(mask &  owner_dma);
  assign win    = win_cpu | win_dma;
  assign w_next = win_dma ? dma_w : cpu_w;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  // Next-state, arbitration and completion decode
  always_comb begin
    state_d     = state;
    win_cpu     = 1'b0;
    win_dma     = 1'b0;
    complete    = 1'b0;
    timeout_hit = 1'b0;
    grant_d     = grant;
    case (state)
      S_IDLE: begin
        grant_d = 2'b00;
        if (dma_ok && (!cpu_req || starve_cnt == SW'(STARVE))) begin
          win_dma = 1'b1;
          grant_d = 2'b10;
          state_d = S_ISSUE;
        end else if (cpu_ok) begin
          win_cpu = 1'b1;
          grant_d = 2'b01;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (w_l ? mem_saverdy : mem_readrdy) begin
          complete = 1'b1;
          state_d  = S_DONE;
        end else if (to_cnt == TW'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        grant_d = 2'b00;
        state_d = S_IDLE;
      end
      default: begin
        grant_d = 2'b00;
        state_d = S_IDLE;
      end
    endcase
  end

  // Transaction latches, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_dma  <= 1'b0;
      w_l        <= 1'b0;
      mask       <= 1'b0;
      starve_cnt <= '0;
      to_cnt     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_w      <= 1'b0;
      mem_start  <= 1'b0;
      grant      <= 2'b00;
      busy       <= 1'b0;
      cpu_done   <= 1'b0;
      dma_done   <= 1'b0;
      err        <= 1'b0;
      cpu_rdata  <= '0;
      dma_rdata  <= '0;
    end else begin
      if (win) begin
        owner_dma <= win_dma;
        w_l       <= w_next;
        mem_addr  <= win_dma ? dma_addr  : cpu_addr;
        mem_wdata <= win_dma ? dma_wdata : cpu_wdata;
      end

      if (win_dma)
        starve_cnt <= '0;
      else if (win_cpu && dma_req && starve_cnt != SW'(STARVE))
        starve_cnt <= starve_cnt + SW'(1);

      if (state == S_WAIT)
        to_cnt <= to_cnt + TW'(1);
      else if (state == S_DONE)
        to_cnt <= '0;

      mask      <= (state == S_DONE);
      mem_start <= win & ~w_next;
      mem_w     <= win &  w_next;
      grant     <= grant_d;
      busy      <= (state_d != S_IDLE);
      cpu_done  <= (complete | timeout_hit) & ~owner_dma;
      dma_done  <= (complete | timeout_hit) &  owner_dma;
      err       <= timeout_hit;

      if (complete && !w_l && !owner_dma) cpu_rdata <= mem_rdata;
      if (complete && !w_l &&  owner_dma) dma_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: table of single transactions plus hand-written
// contention, timeout and mid-transaction reset sequences.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_w, dma_req, dma_w;
  logic [14:0] cpu_addr, dma_addr, mem_addr;
  logic [31:0] cpu_wdata, dma_wdata, cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
  logic        cpu_done, dma_done, err, mem_w, mem_start, mem_readrdy, mem_saverdy, busy;
  logic [1:0]  grant;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_w(cpu_w), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .dma_req(dma_req), .dma_w(dma_w), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_done(dma_done),
    .err(err), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_w(mem_w),
    .mem_start(mem_start), .mem_rdata(mem_rdata), .mem_readrdy(mem_readrdy),
    .mem_saverdy(mem_saverdy), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          dma;
    bit          w;
    logic [14:0] addr;
    logic [31:0] wdata;
    int          dly;        // cycles from strobe to completion rdy
    logic [31:0] mrdata;
    bit          distract;   // wrong-kind rdy during WAIT
    bit          early;      // right-kind rdy during ISSUE
    logic [1:0]  exp_grant;
    logic [31:0] exp_rdata;  // owner's rdata after the transaction
  } vec_t;

  vec_t vecs [8];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   wait_bad;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rdy(input bit w, input bit val);
    if (w) mem_saverdy = val;
    else   mem_readrdy = val;
  endtask

  task automatic wait_chk(input vec_t v);
    if (mem_start !== 1'b0 || mem_w !== 1'b0 || cpu_done !== 1'b0 || dma_done !== 1'b0 ||
        mem_addr !== v.addr || (v.w && mem_wdata !== v.wdata) || grant !== v.exp_grant)
      wait_bad = 1'b1;
  endtask

  task automatic drive_req(input vec_t v, input bit on);
    if (v.dma) begin
      dma_req = on; dma_w = v.w; dma_addr = v.addr; dma_wdata = v.wdata;
    end else begin
      cpu_req = on; cpu_w = v.w; cpu_addr = v.addr; cpu_wdata = v.wdata;
    end
  endtask

  task automatic run_vec(input vec_t v);
    drive_req(v, 1'b1);
    step();  // ISSUE
    chk("issue_start", mem_start, !v.w);
    chk("issue_w", mem_w, v.w);
    chk("issue_grant", grant, v.exp_grant);
    chk("issue_busy", busy, 1);
    chk("issue_addr", mem_addr, v.addr);
    if (v.w) chk("issue_wdata", mem_wdata, v.wdata);
    // requester inputs change after the grant; only latched copies may be used
    if (v.dma) begin dma_addr = ~v.addr; dma_wdata = ~v.wdata; dma_w = ~v.w; end
    else       begin cpu_addr = ~v.addr; cpu_wdata = ~v.wdata; cpu_w = ~v.w; end
    if (v.early) begin mem_rdata = 32'hBAD0BAD0; set_rdy(v.w, 1'b1); end
    step();  // first WAIT cycle
    set_rdy(v.w, 1'b0);
    wait_bad = 1'b0;
    wait_chk(v);
    for (int i = 1; i < v.dly; i++) begin
      if (v.distract && i == 1) begin mem_rdata = 32'hBAD0BAD0; set_rdy(!v.w, 1'b1); end
      step();
      set_rdy(!v.w, 1'b0);
      wait_chk(v);
    end
    chk("wait_hold", wait_bad, 0);
    mem_rdata = v.mrdata;
    set_rdy(v.w, 1'b1);
    step();  // DONE
    set_rdy(v.w, 1'b0);
    mem_rdata = 32'h0;
    chk("done_owner", v.dma ? dma_done : cpu_done, 1);
    chk("done_other", v.dma ? cpu_done : dma_done, 0);
    chk("done_err", err, 0);
    chk("done_grant", grant, v.exp_grant);
    chk("rdata", v.dma ? dma_rdata : cpu_rdata, v.exp_rdata);
    drive_req(v, 1'b0);
    step();  // IDLE, owner masked
    chk("post_done", {cpu_done, dma_done}, 0);
    chk("post_busy", busy, 0);
    chk("post_grant", grant, 0);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] order [$];
    logic [1:0] exp_order [10];
    int         pend;

    vecs[0] = '{0, 0, 15'h0123, 32'h0,        2, 32'hDEADBEEF, 0, 0, 2'b01, 32'hDEADBEEF};
    vecs[1] = '{1, 1, 15'h1800, 32'h0000A5A5, 3, 32'h0,        1, 0, 2'b10, 32'h0};
    vecs[2] = '{1, 0, 15'h7FFF, 32'h0,        1, 32'h12345678, 0, 0, 2'b10, 32'h12345678};
    vecs[3] = '{0, 1, 15'h0000, 32'hFFFFFFFF, 1, 32'h0,        0, 0, 2'b01, 32'hDEADBEEF};
    vecs[4] = '{0, 0, 15'h4AAA, 32'h0,        4, 32'hCAFEF00D, 1, 1, 2'b01, 32'hCAFEF00D};
    vecs[5] = '{1, 1, 15'h2555, 32'h5A5A5A5A, 2, 32'h0,        0, 1, 2'b10, 32'h12345678};
    vecs[6] = '{0, 0, 15'h3210, 32'h0,        1, 32'h0BADF00D, 0, 0, 2'b01, 32'h0BADF00D};
    vecs[7] = '{0, 0, 15'h0042, 32'h0,        1, 32'h600DCAFE, 0, 0, 2'b01, 32'h600DCAFE};
    exp_order = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};

    rst = 1'b1;
    cpu_req = 0; cpu_w = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_w = 0; dma_addr = '0; dma_wdata = '0;
    mem_rdata = '0; mem_readrdy = 0; mem_saverdy = 0;
    #1;
    chk("reset_outs", {cpu_done, dma_done, err, mem_w, mem_start, grant, busy}, 0);
    chk("reset_data", {mem_addr, mem_wdata, cpu_rdata, dma_rdata}, 0);
    step(); step();
    rst = 1'b0;
    step();

    // Single transactions
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Timeout: CPU read with no completion
    cpu_req = 1; cpu_w = 0; cpu_addr = 15'h0055;
    step();
    chk("to_start", mem_start, 1);
    begin
      int early_done = 0;
      for (int i = 0; i < 255; i++) begin
        step();
        if (cpu_done || dma_done) early_done++;
      end
      chk("to_no_early_done", early_done, 0);
    end
    step();
    chk("to_done", cpu_done, 1);
    chk("to_err", err, 1);
    chk("to_rdata_kept", cpu_rdata, 32'hCAFEF00D);
    cpu_req = 0;
    step();
    chk("to_err_pulse", {err, cpu_done}, 0);
    step();
    run_vec(vecs[6]);

    // Contention: both requesters held; writes completed one cycle into WAIT
    cpu_req = 1; cpu_w = 1; cpu_addr = 15'h0100;
    dma_req = 1; dma_w = 1; dma_addr = 15'h0200;
    pend = 0;
    for (int c = 0; c < 60; c++) begin
      step();
      mem_saverdy = (pend != 0);
      pend = 0;
      if (mem_w) begin pend = 1; order.push_back(grant); end
    end
    cpu_req = 0; dma_req = 0;
    for (int c = 0; c < 20 && (busy || pend != 0); c++) begin
      step();
      mem_saverdy = (pend != 0);
      pend = 0;
      if (mem_w) pend = 1;
    end
    mem_saverdy = 0;
    chk("cont_count_ge10", order.size() >= 10, 1);
    for (int i = 0; i < 10; i++)
      chk($sformatf("cont_grant%0d", i), (i < order.size()) ? order[i] : 2'bxx, exp_order[i]);
    chk("cont_drained", busy, 0);
    step(); step();

    // Reset in the middle of a DMA read
    dma_req = 1; dma_w = 0; dma_addr = 15'h0777;
    step(); step(); step();  // WAIT
    chk("rst_pre_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_outs", {cpu_done, dma_done, err, mem_w, mem_start, grant, busy}, 0);
    chk("rst_mid_data", {mem_addr, mem_wdata, cpu_rdata, dma_rdata}, 0);
    dma_req = 0;
    step();
    rst = 1'b0;
    begin
      int dones = 0;
      for (int i = 0; i < 3; i++) begin
        step();
        if (cpu_done || dma_done) dones++;
      end
      chk("rst_no_done", dones, 0);
    end
    run_vec(vecs[7]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
